// File: rtl/mips_reg_file_if.sv
// Register-file bus for the single-cycle MIPS datapath.
// The datapath side (master) drives read/write addresses, writeback data and
// the overflow qualifiers; the register file (slave) returns operands and
// overflow status.
interface mips_reg_file_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [WIDTH-1:0]  read_data1;
  logic [WIDTH-1:0]  read_data2;
  logic [ADDR_W-1:0] write_reg;
  logic [WIDTH-1:0]  write_data;
  logic              reg_write;
  logic              ovf_check;
  logic              alu_overflow;
  logic              write_blocked;
  logic              ovf_sticky;
  logic              ovf_sticky_clr;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
           ovf_check, alu_overflow, ovf_sticky_clr,
    input  read_data1, read_data2, write_blocked, ovf_sticky
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
           ovf_check, alu_overflow, ovf_sticky_clr,
    output read_data1, read_data2, write_blocked, ovf_sticky
  );
endinterface

// File: rtl/mips_reg_file.sv
// 32 x 32-bit MIPS general-purpose register file.
// Two combinational read ports feed the ALU operands; one write port takes
// the writeback result. A write flagged as a trapping signed overflow is
// suppressed and recorded in a sticky status bit. r0 is hardwired to zero.
module mips_reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  mips_reg_file_if.slave  rf
);
  localparam int NREGS = 1 << ADDR_W;

  logic             write_blocked;
  logic             write_nonzero;
  logic             we_eff;
  logic             sticky_set;
  logic             ovf_sticky_reg;
  logic [WIDTH-1:0] rd1_next;
  logic [WIDTH-1:0] rd2_next;
  logic [WIDTH-1:0] reg_bank [NREGS];

  // Overflow trap qualifies the write; r0 writes are dropped entirely,
  // including their effect on the sticky bit. Reset cancels any write.
  assign write_blocked = rf.reg_write & rf.ovf_check & rf.alu_overflow;
  assign write_nonzero = (rf.write_reg != '0);
  assign we_eff        = rf.reg_write & ~write_blocked & ~reset & write_nonzero;
  assign sticky_set    = write_blocked & write_nonzero;

  // Storage: r0 is a constant, r1..r31 are individually resettable flops so
  // that a single reset cycle clears the whole file.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign reg_bank[gi] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] q_reg;
        // Capture writeback data when this register is the effective target.
        always_ff @(posedge clk) begin
          if (reset) begin
            q_reg <= '0;
          end else if (we_eff && (rf.write_reg == ADDR_W'(gi))) begin
            q_reg <= rf.write_data;
          end
        end
        assign reg_bank[gi] = q_reg;
      end
    end
  endgenerate

  // Read port 1: stored value, optionally forwarded from a same-cycle write.
  always_comb begin
    rd1_next = reg_bank[rf.read_reg1];
    if ((BYPASS != 0) && we_eff && (rf.read_reg1 == rf.write_reg)) begin
      rd1_next = rf.write_data;
    end
    if (rf.read_reg1 == '0) begin
      rd1_next = '0;
    end
  end

  // Read port 2: same resolution as port 1, independent address.
  always_comb begin
    rd2_next = reg_bank[rf.read_reg2];
    if ((BYPASS != 0) && we_eff && (rf.read_reg2 == rf.write_reg)) begin
      rd2_next = rf.write_data;
    end
    if (rf.read_reg2 == '0) begin
      rd2_next = '0;
    end
  end

  // Sticky overflow status: reset beats set, set beats clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky_reg <= 1'b0;
    end else if (sticky_set) begin
      ovf_sticky_reg <= 1'b1;
    end else if (rf.ovf_sticky_clr) begin
      ovf_sticky_reg <= 1'b0;
    end
  end

  assign rf.read_data1    = rd1_next;
  assign rf.read_data2    = rd2_next;
  assign rf.write_blocked = write_blocked;
  assign rf.ovf_sticky    = ovf_sticky_reg;
endmodule

// File: tb/tb_mips_reg_file.sv
// Directed bench for mips_reg_file. Two instances run the same stimulus:
// one with same-cycle forwarding enabled, one without.
module tb_mips_reg_file;
  logic        clk;
  logic        reset;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic        ovf_check;
  logic        alu_overflow;
  logic        ovf_sticky_clr;

  int vec_cnt;
  int err_cnt;

  mips_reg_file_if #(.WIDTH(32), .ADDR_W(5)) bus_byp ();
  mips_reg_file_if #(.WIDTH(32), .ADDR_W(5)) bus_nob ();

  assign bus_byp.read_reg1      = read_reg1;
  assign bus_byp.read_reg2      = read_reg2;
  assign bus_byp.write_reg      = write_reg;
  assign bus_byp.write_data     = write_data;
  assign bus_byp.reg_write      = reg_write;
  assign bus_byp.ovf_check      = ovf_check;
  assign bus_byp.alu_overflow   = alu_overflow;
  assign bus_byp.ovf_sticky_clr = ovf_sticky_clr;

  assign bus_nob.read_reg1      = read_reg1;
  assign bus_nob.read_reg2      = read_reg2;
  assign bus_nob.write_reg      = write_reg;
  assign bus_nob.write_data     = write_data;
  assign bus_nob.reg_write      = reg_write;
  assign bus_nob.ovf_check      = ovf_check;
  assign bus_nob.alu_overflow   = alu_overflow;
  assign bus_nob.ovf_sticky_clr = ovf_sticky_clr;

  mips_reg_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) u_dut_byp (
    .clk   (clk),
    .reset (reset),
    .rf    (bus_byp.slave)
  );

  mips_reg_file #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) u_dut_nob (
    .clk   (clk),
    .reset (reset),
    .rf    (bus_nob.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write      = 1'b0;
    ovf_check      = 1'b0;
    alu_overflow   = 1'b0;
    ovf_sticky_clr = 1'b0;
    write_reg      = 5'd0;
    write_data     = 32'h0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    reg_write  = 1'b1;
    write_reg  = a;
    write_data = d;
  endtask

  task automatic chk_all_zero(input string phase);
    for (int a = 0; a < 32; a++) begin
      read_reg1 = 5'(a);
      read_reg2 = 5'(a);
      #1;
      chk($sformatf("%s byp rd1 r%0d", phase, a), bus_byp.read_data1, 32'h0);
      chk($sformatf("%s byp rd2 r%0d", phase, a), bus_byp.read_data2, 32'h0);
      chk($sformatf("%s nob rd1 r%0d", phase, a), bus_nob.read_data1, 32'h0);
      chk($sformatf("%s nob rd2 r%0d", phase, a), bus_nob.read_data2, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    reset     = 1'b1;
    read_reg1 = 5'd0;
    read_reg2 = 5'd0;
    idle();
    #1;
    tick();
    tick();
    reset = 1'b0;

    // After reset: every address reads zero, sticky clear.
    chk_all_zero("reset");
    chk("reset byp sticky", 32'(bus_byp.ovf_sticky), 32'h0);
    chk("reset nob sticky", 32'(bus_nob.ovf_sticky), 32'h0);

    // r5 <= DEADBEEF, visible next cycle.
    wr(5'd5, 32'hDEADBEEF);
    tick();
    idle();
    read_reg1 = 5'd5;
    #1;
    chk("r5 byp rd1", bus_byp.read_data1, 32'hDEADBEEF);
    chk("r5 nob rd1", bus_nob.read_data1, 32'hDEADBEEF);

    // r0 write is discarded, never forwarded.
    wr(5'd0, 32'hFFFFFFFF);
    read_reg1 = 5'd0;
    #1;
    chk("r0 same-cycle byp rd1", bus_byp.read_data1, 32'h0);
    tick();
    idle();
    #1;
    chk("r0 after byp rd1", bus_byp.read_data1, 32'h0);
    chk("r0 after nob rd1", bus_nob.read_data1, 32'h0);

    // Read-during-write on r7: old value 11111111, new 12345678.
    wr(5'd7, 32'h11111111);
    tick();
    wr(5'd7, 32'h12345678);
    read_reg2 = 5'd7;
    #1;
    chk("r7 rdw byp rd2", bus_byp.read_data2, 32'h12345678);
    chk("r7 rdw nob rd2", bus_nob.read_data2, 32'h11111111);
    tick();
    idle();
    #1;
    chk("r7 next byp rd2", bus_byp.read_data2, 32'h12345678);
    chk("r7 next nob rd2", bus_nob.read_data2, 32'h12345678);

    // Blocked write on r3 (holds 1): no storage change, no forward, sticky set.
    wr(5'd3, 32'h1);
    tick();
    wr(5'd3, 32'h80000000);
    ovf_check    = 1'b1;
    alu_overflow = 1'b1;
    read_reg1    = 5'd3;
    read_reg2    = 5'd3;
    #1;
    chk("blk byp write_blocked", 32'(bus_byp.write_blocked), 32'h1);
    chk("blk nob write_blocked", 32'(bus_nob.write_blocked), 32'h1);
    chk("blk byp rd1 no fwd", bus_byp.read_data1, 32'h1);
    chk("blk byp rd2 no fwd", bus_byp.read_data2, 32'h1);
    tick();
    idle();
    #1;
    chk("blk byp r3 kept", bus_byp.read_data1, 32'h1);
    chk("blk nob r3 kept", bus_nob.read_data1, 32'h1);
    chk("blk byp sticky", 32'(bus_byp.ovf_sticky), 32'h1);
    chk("blk nob sticky", 32'(bus_nob.ovf_sticky), 32'h1);

    // Set beats simultaneous clear.
    wr(5'd3, 32'h80000000);
    ovf_check      = 1'b1;
    alu_overflow   = 1'b1;
    ovf_sticky_clr = 1'b1;
    tick();
    idle();
    #1;
    chk("set+clr byp sticky", 32'(bus_byp.ovf_sticky), 32'h1);

    // Clear alone.
    ovf_sticky_clr = 1'b1;
    tick();
    idle();
    #1;
    chk("clr byp sticky", 32'(bus_byp.ovf_sticky), 32'h0);
    chk("clr nob sticky", 32'(bus_nob.ovf_sticky), 32'h0);

    // ovf_check=0: overflow ignored, write completes, sticky untouched.
    wr(5'd3, 32'h80000000);
    alu_overflow = 1'b1;
    #1;
    chk("unsigned byp write_blocked", 32'(bus_byp.write_blocked), 32'h0);
    chk("unsigned byp rd1 fwd", bus_byp.read_data1, 32'h80000000);
    chk("unsigned nob rd1 old", bus_nob.read_data1, 32'h1);
    tick();
    idle();
    #1;
    chk("unsigned byp r3", bus_byp.read_data1, 32'h80000000);
    chk("unsigned nob r3", bus_nob.read_data1, 32'h80000000);
    chk("unsigned byp sticky", 32'(bus_byp.ovf_sticky), 32'h0);

    // Blocked write to r0: write_blocked asserts but sticky is not set.
    wr(5'd0, 32'h12345678);
    ovf_check    = 1'b1;
    alu_overflow = 1'b1;
    #1;
    chk("r0 blk byp write_blocked", 32'(bus_byp.write_blocked), 32'h1);
    tick();
    idle();
    #1;
    chk("r0 blk byp sticky", 32'(bus_byp.ovf_sticky), 32'h0);
    chk("r0 blk nob sticky", 32'(bus_nob.ovf_sticky), 32'h0);

    // Fill r1..r31 with distinct values and read them back on both ports.
    for (int a = 1; a < 32; a++) begin
      wr(5'(a), {16'hC0DE, 16'(a)});
      tick();
    end
    idle();
    for (int a = 1; a < 32; a++) begin
      read_reg1 = 5'(a);
      read_reg2 = 5'(32 - a);
      #1;
      chk($sformatf("fill byp rd1 r%0d", a), bus_byp.read_data1, {16'hC0DE, 16'(a)});
      chk($sformatf("fill nob rd2 r%0d", 32 - a), bus_nob.read_data2, {16'hC0DE, 16'(32 - a)});
    end

    // Set sticky so the reset cycle has something to clear.
    wr(5'd4, 32'h0BADF00D);
    ovf_check    = 1'b1;
    alu_overflow = 1'b1;
    tick();
    idle();
    #1;
    chk("pre-reset byp sticky", 32'(bus_byp.ovf_sticky), 32'h1);

    // Reset together with a write of r9: reset wins, nothing forwarded.
    reset     = 1'b1;
    wr(5'd9, 32'hAAAA5555);
    read_reg1 = 5'd9;
    #1;
    chk("rst-cycle byp rd1 no fwd", bus_byp.read_data1, 32'hC0DE0009);
    tick();
    reset = 1'b0;
    idle();
    read_reg1 = 5'd9;
    read_reg2 = 5'd9;
    #1;
    chk("post-rst byp r9", bus_byp.read_data1, 32'h0);
    chk("post-rst nob r9", bus_nob.read_data2, 32'h0);
    chk("post-rst byp sticky", 32'(bus_byp.ovf_sticky), 32'h0);
    chk("post-rst nob sticky", 32'(bus_nob.ovf_sticky), 32'h0);
    chk_all_zero("post-rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
